// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read channel plus the decode-stage handshake.
// The master modport is the fetch unit; the slave modport is its memory/decode environment.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] pc;

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid, pc,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid, pc,
        output imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word at pc, holds it for decode, then advances
// pc sequentially or by a taken branch, stopping on the halt opcode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          halted,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        halted_q;

    logic [31:0] pc_seq_d;
    logic [31:0] pc_d;

    // Next pc on a handshake; the word offset is sign-extended and scaled to bytes.
    always_comb begin
        pc_seq_d = pc_q + 32'd4;
        if (bus.branch_taken) begin
            pc_d = pc_seq_d + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
        end else begin
            pc_d = pc_seq_d;
        end
    end

    // Fetch FSM with registered outputs; async reset drops imem_req immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0000_0000;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        state_q <= HOLD;
                        instr_q <= bus.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        if (instr_q[31:26] == HALT_OPCODE) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    req_q    <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    req_q    <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, reset corner cases,
// then randomized ack/ready/branch traffic against a transaction-level pc model.
module tb_instr_fetch;

    logic clk;
    logic reset;
    logic start;
    logic halted;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .halted (halted),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        taken;
        logic [15:0] off;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_halted;
    } vec_t;

    vec_t        vq[$];
    int          checks;
    int          errors;
    logic [31:0] exp_pc;
    logic        m_hold;
    logic        r_ack;
    logic        r_ready;
    logic        r_taken;
    int          so;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents used by the random phase; never yields the halt opcode.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (w[31:26] == 6'h3F) w[26] = 1'b0;
        return w;
    endfunction

    task automatic chk_state(input string tag, input logic e_req, input logic e_valid,
                             input logic [31:0] e_pc, input logic e_halted);
        chk({tag, " imem_req"},    {31'd0, bus.imem_req},    {31'd0, e_req});
        chk({tag, " instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, e_valid});
        chk({tag, " pc"},          bus.pc,                   e_pc);
        chk({tag, " halted"},      {31'd0, halted},          {31'd0, e_halted});
        if (e_req) chk({tag, " imem_addr"}, bus.imem_addr, e_pc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0000_0000;
        bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_offset = 16'h0000;

        #1;
        chk_state("reset", 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        chk("reset instr", bus.instr, 32'h0000_0000);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk_state("idle", 1'b0, 1'b0, 32'h0000_0000, 1'b0);

        // start ack rdata ready taken off | req valid instr pc halted
        vq.push_back('{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0000_0000, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h0400_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0400_0000, 32'h0000_0000, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h0400_0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0000_0004, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h0800_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0800_0000, 32'h0000_0004, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h0800_0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0000_0008, 1'b0});
        for (int k = 0; k < 3; k++)
            vq.push_back('{1'b1, 1'b0, 32'h0C00_0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 32'h0, 32'h0000_0008, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h0C00_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0C00_0000, 32'h0000_0008, 1'b0});
        for (int k = 0; k < 5; k++)
            vq.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 32'h0C00_0000, 32'h0000_0008, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0000_000C, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h1000_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h1000_0000, 32'h0000_000C, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0000_0010, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h0400_0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0400_0001, 32'h0000_0010, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 32'h0, 32'h0000_000C, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h1400_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h1400_0000, 32'h0000_000C, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0000_0010, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h1800_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h1800_0000, 32'h0000_0010, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 16'hFFFA, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h2000_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h2000_0000, 32'hFFFF_FFFC, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0000_0000, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'hFC00_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hFC00_0000, 32'h0000_0000, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'hFC00_0000, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 32'hFC00_0000, 32'h0000_0000, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1});
        vq.push_back('{1'b1, 1'b1, 32'h0400_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1});
        vq.push_back('{1'b1, 1'b1, 32'h0400_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1});

        foreach (vq[i]) begin
            start = vq[i].start;
            bus.imem_ack = vq[i].ack;
            bus.imem_rdata = vq[i].rdata;
            bus.instr_ready = vq[i].ready;
            bus.branch_taken = vq[i].taken;
            bus.branch_offset = vq[i].off;
            step();
            chk_state($sformatf("row%0d", i), vq[i].e_req, vq[i].e_valid, vq[i].e_pc, vq[i].e_halted);
            if (vq[i].e_valid) begin
                chk($sformatf("row%0d instr", i), bus.instr, vq[i].e_instr);
                chk($sformatf("row%0d opcode", i), {26'd0, bus.opcode}, {26'd0, vq[i].e_instr[31:26]});
            end
        end
        start = 1'b0;
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b0;

        // Reset out of HALT takes effect without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk_state("halt reset", 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk_state("post reset idle", 1'b0, 1'b0, 32'h0000_0000, 1'b0);

        // Reset mid-FETCH with an ack pending: request drops before the next edge.
        start = 1'b1;
        step();
        start = 1'b0;
        chk_state("refetch", 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h0400_0000;
        #2;
        reset = 1'b1;
        #1;
        chk_state("reset mid fetch", 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        step();
        reset = 1'b0;
        step();
        step();
        chk_state("ack after reset", 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        bus.imem_ack = 1'b0;

        // Random traffic: model tracks only whether an instruction is held and the expected pc.
        exp_pc = 32'h0000_0000;
        m_hold = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_state("rand start", 1'b1, 1'b0, exp_pc, 1'b0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r_ack = ($urandom_range(0, 3) != 0);
            r_ready = ($urandom_range(0, 3) != 0);
            r_taken = ($urandom_range(0, 1) != 0);
            so = int'($urandom_range(0, 127)) - 64;
            bus.imem_ack = r_ack;
            bus.instr_ready = r_ready;
            bus.branch_taken = r_taken;
            bus.branch_offset = so[15:0];
            bus.imem_rdata = m_hold ? 32'($urandom) : instr_at(bus.imem_addr);
            step();
            if (!m_hold) begin
                if (r_ack) m_hold = 1'b1;
            end else if (r_ready) begin
                exp_pc = exp_pc + 32'd4 + (r_taken ? 32'(so * 4) : 32'd0);
                m_hold = 1'b0;
            end
            chk_state($sformatf("rand%0d", cyc), !m_hold, m_hold, exp_pc, 1'b0);
            if (m_hold) chk($sformatf("rand%0d instr", cyc), bus.instr, instr_at(exp_pc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 6'b111111: the opcode that stops fetching.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: single-cycle pulse that begins fetching from IDLE.
REQ-006 The block SHALL have port imem_req, output, 1: instruction-memory read request.
REQ-007 The block SHALL have port imem_addr, output, 32: byte address of the requested instruction (equals pc).
REQ-008 The block SHALL have port imem_ack, input, 1: memory read done; imem_rdata is valid in this cycle.
REQ-009 The block SHALL have port imem_rdata, input, 32: instruction word from memory.
REQ-010 The block SHALL have port instr, output, 32: registered instruction presented to the decode stage.
REQ-011 The block SHALL have port opcode, output, 6: instr[31:26], fed to the controller's opcode input.
REQ-012 The block SHALL have port instr_valid, output, 1: instr/opcode/pc hold a fetched instruction.
REQ-013 The block SHALL have port instr_ready, input, 1: the decode stage accepts the instruction this cycle.
REQ-014 The block SHALL have port branch_taken, input, 1: the accepted instruction is a taken branch (controller Branch qualified by ALU zero/not-zero).
REQ-015 The block SHALL have port branch_offset, input, 16: signed word offset of the taken branch.
REQ-016 The block SHALL have port pc, output, 32: address of the instruction currently held or requested.
REQ-017 The block SHALL have port halted, output, 1: the block is in HALT.

Function
REQ-018 The block SHALL implement four states: IDLE, FETCH, HOLD and HALT.
REQ-019 In IDLE, start=1 SHALL move to FETCH on the next edge; start SHALL be ignored in all other states.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack=1.
REQ-021 imem_ack=1 in FETCH SHALL capture imem_rdata into instr and move to HOLD, including when ack arrives in the first FETCH cycle.
REQ-022 imem_ack SHALL be ignored outside FETCH.
REQ-023 instr_valid SHALL be 1 exactly in HOLD; instr, opcode and pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-024 A handshake (instr_valid=1 and instr_ready=1) with opcode != HALT_OPCODE SHALL move to FETCH.
REQ-025 On that handshake, pc SHALL update to pc+4 when branch_taken=0.
REQ-026 On that handshake, pc SHALL update to pc+4+(sign_extend(branch_offset)<<2) when branch_taken=1.
REQ-027 All pc arithmetic SHALL be modulo 2^32 and wrap silently.
REQ-028 branch_taken and branch_offset SHALL be ignored in every cycle without a handshake.
REQ-029 A handshake with opcode == HALT_OPCODE SHALL move to HALT and leave pc unchanged.
REQ-030 In HALT, halted SHALL be 1 and imem_req and instr_valid SHALL be 0; only reset exits HALT.
REQ-031 Minimum latency SHALL be: start at edge N gives imem_req=1 after N; ack in cycle K gives instr_valid=1 after edge K.
REQ-032 Sustained throughput SHALL be one instruction per two cycles when ack and ready are always 1.

Reset
REQ-033 Asserting reset SHALL immediately, without waiting for a clock edge, set: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0.
REQ-034 Reset mid-fetch SHALL drop imem_req in the same cycle; an imem_ack arriving during or after reset SHALL be ignored.
REQ-035 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-036 Bench SHALL cover: reset, start, ack=1 every cycle, ready=1, rdata=32'h0400_0000 then 32'h0800_0000 -> imem_addr 0,4; opcodes 6'h01, 6'h02; instr_valid every second cycle.
REQ-037 Bench SHALL cover: ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; instr_valid one cycle after ack.
REQ-038 Bench SHALL cover: instr_valid with ready=0 for 5 cycles -> instr and pc unchanged; then ready=1 -> next FETCH at pc+4.
REQ-039 Bench SHALL cover: pc=0x10, handshake with branch_taken=1 and offset=16'hFFFE -> next imem_addr=0x0C.
REQ-040 Bench SHALL cover: pc=0xFFFF_FFFC, no branch -> next pc=0x0000_0000 (wrap).
REQ-041 Bench SHALL cover: rdata=32'hFC00_0000 accepted -> halted=1, imem_req=0 thereafter; start ignored; reset asserted mid-FETCH -> imem_req=0 before the next edge.
